// File: rtl/branch_recovery_ctrl_if.sv
// Branch-resolution / fetch-redirect bundle for branch_recovery_ctrl.
// master = EX/fetch side driving branches, slave = recovery controller.
interface branch_recovery_ctrl_if #(
    parameter int WIDTH_DATA_LENGTH = 32
);
    logic                         br_valid;
    logic [1:0]                   br_result;
    logic                         br_taken;
    logic [WIDTH_DATA_LENGTH-1:0] br_pc;
    logic [WIDTH_DATA_LENGTH-1:0] pc_alu;
    logic [WIDTH_DATA_LENGTH-1:0] pred_pc;
    logic                         pred_taken;
    logic                         fetch_ready;
    logic                         redirect_valid;
    logic [WIDTH_DATA_LENGTH-1:0] redirect_pc;
    logic                         flush_if;
    logic                         flush_id;
    logic                         stall_ex;

    modport master (
        output br_valid, br_result, br_taken,
        output br_pc, pc_alu, pred_pc, fetch_ready,
        input  pred_taken, redirect_valid, redirect_pc,
        input  flush_if, flush_id, stall_ex
    );

    modport slave (
        input  br_valid, br_result, br_taken,
        input  br_pc, pc_alu, pred_pc, fetch_ready,
        output pred_taken, redirect_valid, redirect_pc,
        output flush_if, flush_id, stall_ex
    );
endinterface

// File: rtl/branch_recovery_ctrl.sv
// Branch misprediction recovery FSM with a 2-bit counter BHT.
// Optional BRANCH_STATS_EN adds saturating branch/mispredict counters.
module branch_recovery_ctrl #(
    parameter int WIDTH_DATA_LENGTH = 32,
    parameter int BHT_ENTRIES       = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    branch_recovery_ctrl_if.slave bus
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]           branch_cnt,
    output logic [15:0]           mispredict_cnt
`endif
);
    localparam int IDX_W = $clog2(BHT_ENTRIES);
    localparam int W     = WIDTH_DATA_LENGTH;

    typedef enum logic [1:0] {
        IDLE,
        FLUSH,
        REDIRECT
    } state_t;

    state_t         state;
    logic           redirect_q;
    logic           flush_q;
    logic [W-1:0]   redirect_pc_q;
    logic [1:0]     bht [BHT_ENTRIES];
    logic           accept;
    logic           mispredict;
    logic [IDX_W-1:0] upd_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [W-1:0]   target;
    logic           unused_pred;

    assign accept     = bus.br_valid && (state == IDLE);
    assign mispredict = (bus.br_result != 2'b01);
    assign upd_idx    = bus.br_pc[IDX_W+1:2];
    assign rd_idx     = bus.pred_pc[IDX_W+1:2];
    assign unused_pred = ^{bus.pred_pc[W-1:IDX_W+2],
                           bus.pred_pc[1:0]};

    // Return-type resolution falls through to br_pc+4; others use ALU target
    always_comb begin
        target = bus.pc_alu;
        unique case (1'b1)
            (bus.br_result == 2'b10): target = bus.br_pc + W'(4);
            default:                  target = bus.pc_alu;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            redirect_q    <= 1'b0;
            flush_q       <= 1'b0;
            redirect_pc_q <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept && mispredict) begin
                        state         <= FLUSH;
                        flush_q       <= 1'b1;
                        redirect_pc_q <= target;
                    end
                end
                FLUSH: begin
                    state      <= REDIRECT;
                    flush_q    <= 1'b0;
                    redirect_q <= 1'b1;
                end
                REDIRECT: begin
                    if (bus.fetch_ready) begin
                        state      <= IDLE;
                        redirect_q <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    flush_q    <= 1'b0;
                    redirect_q <= 1'b0;
                end
            endcase
        end
    end

    // Counters only move on accepted branches; busy-state br_valid is dropped
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht[i] <= 2'b01;
            end
        end else if (accept) begin
            if (bus.br_taken) begin
                if (bht[upd_idx] != 2'b11) begin
                    bht[upd_idx] <= bht[upd_idx] + 2'd1;
                end
            end else begin
                if (bht[upd_idx] != 2'b00) begin
                    bht[upd_idx] <= bht[upd_idx] - 2'd1;
                end
            end
        end
    end

    assign bus.pred_taken     = bht[rd_idx][1];
    assign bus.redirect_valid = redirect_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.flush_if       = flush_q;
    assign bus.flush_id       = flush_q;
    assign bus.stall_ex       = (state != IDLE);

`ifdef BRANCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_cnt     <= '0;
            mispredict_cnt <= '0;
        end else if (accept) begin
            if (branch_cnt != 16'hFFFF) begin
                branch_cnt <= branch_cnt + 16'd1;
            end
            if (mispredict && mispredict_cnt != 16'hFFFF) begin
                mispredict_cnt <= mispredict_cnt + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_recovery_ctrl.sv
// Scoreboard bench for branch_recovery_ctrl: directed cases plus random
// branches checked against a counter-array / redirect-queue model.
module tb_branch_recovery_ctrl;
    localparam int W    = 32;
    localparam int N    = 16;
    localparam int IW   = $clog2(N);

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    branch_recovery_ctrl_if #(.WIDTH_DATA_LENGTH(W)) bus();

`ifdef BRANCH_STATS_EN
    logic [15:0] branch_cnt;
    logic [15:0] mispredict_cnt;
    branch_recovery_ctrl #(
        .WIDTH_DATA_LENGTH(W),
        .BHT_ENTRIES(N)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus),
        .branch_cnt(branch_cnt),
        .mispredict_cnt(mispredict_cnt)
    );
`else
    branch_recovery_ctrl #(
        .WIDTH_DATA_LENGTH(W),
        .BHT_ENTRIES(N)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );
`endif

    int checks = 0;
    int failures = 0;
    int bht [N];
    logic [31:0] exp_q [$];
    int m_br = 0;
    int m_mis = 0;

    function automatic void chk(string name, logic [31:0] act,
                                logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endfunction

    function automatic int idx(logic [31:0] pc);
        return int'(pc[IW+1:2]);
    endfunction

    function automatic logic [31:0] pred_of(logic [31:0] pc);
        return (bht[idx(pc)] >= 2) ? 32'd1 : 32'd0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) bht[i] = 1;
        exp_q.delete();
        m_br = 0;
        m_mis = 0;
    endtask

    // One clock of stimulus; acc says the model expects this to be accepted
    task automatic drive(input logic v, input logic [1:0] r,
                         input logic tk, input logic [31:0] bpc,
                         input logic [31:0] alu, input logic fr,
                         input logic [31:0] ppc, input bit acc);
        int i;
        bus.br_valid = v;
        bus.br_result = r;
        bus.br_taken = tk;
        bus.br_pc = bpc;
        bus.pc_alu = alu;
        bus.fetch_ready = fr;
        bus.pred_pc = ppc;
        #1;
        chk("pred_taken", 32'(bus.pred_taken), pred_of(ppc));
        @(posedge clk);
        if (acc) begin
            i = idx(bpc);
            if (tk) bht[i] = (bht[i] < 3) ? bht[i] + 1 : 3;
            else bht[i] = (bht[i] > 0) ? bht[i] - 1 : 0;
            m_br++;
            if (r != 2'b01) begin
                m_mis++;
                exp_q.push_back((r == 2'b10) ? bpc + 32'd4 : alu);
            end
        end
        #1;
    endtask

    task automatic idle_cycle();
        drive(1'b0, 2'($urandom), 1'($urandom), $urandom,
              $urandom, 1'($urandom), $urandom, 1'b0);
    endtask

    task automatic chk_outs(string tag, logic fl, logic rv, logic st);
        chk({tag, "_flush_if"}, 32'(bus.flush_if), 32'(fl));
        chk({tag, "_flush_id"}, 32'(bus.flush_id), 32'(fl));
        chk({tag, "_redirect_valid"}, 32'(bus.redirect_valid), 32'(rv));
        chk({tag, "_stall_ex"}, 32'(bus.stall_ex), 32'(st));
    endtask

    // Full branch episode: accept, then FLUSH, w stalled REDIRECT cycles,
    // and the completing cycle; noise injects br_valid that must be ignored
    task automatic branch(input logic [1:0] r, input logic tk,
                          input logic [31:0] bpc, input logic [31:0] alu,
                          input int w, input bit noise);
        drive(1'b1, r, tk, bpc, alu, 1'($urandom), $urandom, 1'b1);
        if (r == 2'b01) begin
            chk_outs("correct", 1'b0, 1'b0, 1'b0);
            return;
        end
        chk_outs("flush", 1'b1, 1'b0, 1'b1);
        drive(noise, 2'($urandom), 1'b1, bpc, $urandom, 1'b0,
              bpc, 1'b0);
        chk_outs("redir", 1'b0, 1'b1, 1'b1);
        for (int k = 0; k < w; k++) begin
            drive(noise, 2'($urandom), 1'b1, bpc, $urandom, 1'b0,
                  $urandom, 1'b0);
            chk_outs("hold", 1'b0, 1'b1, 1'b1);
        end
        drive(noise, 2'($urandom), 1'b1, bpc, $urandom, 1'b1,
              bpc, 1'b0);
        chk_outs("done", 1'b0, 1'b0, 1'b0);
    endtask

    // Redirect scoreboard: every presented redirect must match the head
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (rst_n && bus.redirect_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_redirect actual=%h required=none",
                             bus.redirect_pc);
                end else begin
                    chk("redirect_pc", bus.redirect_pc, exp_q[0]);
                    if (bus.fetch_ready) void'(exp_q.pop_front());
                end
            end
        end
    endtask

    initial begin
        bus.br_valid = 1'b0;
        bus.br_result = 2'b01;
        bus.br_taken = 1'b0;
        bus.br_pc = '0;
        bus.pc_alu = '0;
        bus.pred_pc = '0;
        bus.fetch_ready = 1'b0;
        model_reset();
        fork
            monitor();
        join_none

        #12;
        chk_outs("reset", 1'b0, 1'b0, 1'b0);
        chk("reset_redirect_pc", bus.redirect_pc, 32'd0);
        chk("reset_pred", 32'(bus.pred_taken), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        idle_cycle();

        // Correct branch trains counter 0 to weakly taken
        branch(2'b01, 1'b1, 32'h40, 32'h0, 0, 1'b0);
        drive(1'b0, 2'b01, 1'b0, 32'h0, 32'h0, 1'b0, 32'h40, 1'b0);
        chk("req033_pred", 32'(bus.pred_taken), 32'd1);

        branch(2'b11, 1'b0, 32'h200, 32'h100, 0, 1'b0);
        branch(2'b10, 1'b1, 32'hFFFF_FFFC, 32'h1234, 1, 1'b0);
        branch(2'b00, 1'b1, 32'h88, 32'h500, 5, 1'b1);
        drive(1'b0, 2'b01, 1'b0, 32'h0, 32'h0, 1'b0, 32'h88, 1'b0);

        for (int t = 0; t < 150; t++) begin
            branch(2'($urandom), 1'($urandom), $urandom, $urandom,
                   int'($urandom_range(0, 4)), 1'($urandom));
            repeat ($urandom_range(0, 2)) idle_cycle();
        end

        // Async reset in the middle of FLUSH
        drive(1'b1, 2'b00, 1'b1, 32'h44, 32'hABC0, 1'b0, 32'h44, 1'b1);
        chk_outs("pre_rst", 1'b1, 1'b0, 1'b1);
        bus.br_valid = 1'b0;
        bus.pred_pc = 32'h44;
        #2 rst_n = 1'b0;
        #1;
        chk_outs("async_rst", 1'b0, 1'b0, 1'b0);
        chk("async_rst_pc", bus.redirect_pc, 32'd0);
        model_reset();
        chk("async_rst_pred", 32'(bus.pred_taken), pred_of(32'h44));
        @(posedge clk);
        #3 rst_n = 1'b1;
        repeat (3) begin
            idle_cycle();
            chk_outs("post_rst", 1'b0, 1'b0, 1'b0);
        end

        branch(2'b01, 1'b1, $urandom, $urandom, 0, 1'b0);
        branch(2'b11, 1'b0, $urandom, $urandom, 1, 1'b0);
        branch(2'b01, 1'b0, $urandom, $urandom, 0, 1'b0);
        branch(2'b10, 1'b1, $urandom, $urandom, 2, 1'b1);
        branch(2'b01, 1'b1, $urandom, $urandom, 0, 1'b0);
        idle_cycle();
`ifdef BRANCH_STATS_EN
        chk("branch_cnt", 32'(branch_cnt), 32'(m_br));
        chk("mispredict_cnt", 32'(mispredict_cnt), 32'(m_mis));
`endif
        chk("pending_redirects", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
